// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared types for the ID/issue hazard scoreboard.
//   - clog2_min1   : index width that never collapses to zero bits
//   - fwd_sel_t    : forwarding select for the default 3-stage bypass network
//                    (0 = register file, k = stage k-1)
//   - long_unit_e  : long-latency unit identifiers for the default config
//   - hazard_t     : the four independent reasons an issue can be held
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_NUM_UNITS  = 2;
    localparam int DEF_FWD_STAGES = 3;
    localparam int DEF_CNT_W      = 32;

    // A single-unit build still needs a 1-bit unit/owner field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_UW = clog2_min1(DEF_NUM_UNITS);
    localparam int DEF_FW = $clog2(DEF_FWD_STAGES + 1);

    typedef logic [DEF_FW-1:0] fwd_sel_t;

    typedef enum logic [DEF_UW-1:0] {
        LU_LOAD = 'd0,
        LU_DIV  = 'd1
    } long_unit_e;

    typedef struct packed {
        logic raw;            // a source is owned by an outstanding long op
        logic waw;            // destination is owned by an outstanding long op
        logic unit_conflict;  // target long unit already has its one op in flight
        logic fwd_stall;      // youngest producer of a source is not ready yet
    } hazard_t;

endpackage

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Per-register pending bit plus owning unit for long-latency writebacks.
//   Register 0 is hard-wired zero and is never marked pending.
//
//   Ports
//     clk, reset_n      clock, asynchronous active-low reset
//     set_en            mark set_rd pending, owned by set_unit
//     set_rd, set_unit  destination register and owning unit
//     clr_mask          per-unit clear: drop every register owned by unit u
//     rs1/rs2/rd_addr   three read addresses
//     rs1/rs2/rd_pending pending bit at each read address
// ---------------------------------------------------------------------------
module reg_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS  = DEF_NUM_REGS,
    parameter  int NUM_UNITS = DEF_NUM_UNITS,
    localparam int RW        = $clog2(NUM_REGS),
    localparam int UW        = clog2_min1(NUM_UNITS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_en,
    input  logic [RW-1:0]        set_rd,
    input  logic [UW-1:0]        set_unit,
    input  logic [NUM_UNITS-1:0] clr_mask,
    input  logic [RW-1:0]        rs1_addr,
    input  logic [RW-1:0]        rs2_addr,
    input  logic [RW-1:0]        rd_addr,
    output logic                 rs1_pending,
    output logic                 rs2_pending,
    output logic                 rd_pending
);

    logic [NUM_REGS-1:0] pending;
    logic [UW-1:0]       owner [NUM_REGS];

    // NOTE: owner is a small flop array, not a RAM, so it is reset along with
    // pending; a true memory macro would be left unreset and gated by pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            owner   <= '{default: '0};
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (pending[r] && clr_mask[owner[r]]) begin
                    pending[r] <= 1'b0;
                end
            end
            // A set is never aimed at a register another unit is clearing
            // (the WAW check blocks it), so placing it after the clears only
            // matters for a unit that clears and re-issues, where set wins.
            if (set_en && (set_rd != '0)) begin
                pending[set_rd] <= 1'b1;
                owner[set_rd]   <= set_unit;
            end
        end
    end

    assign rs1_pending = pending[rs1_addr];
    assign rs2_pending = pending[rs2_addr];
    assign rd_pending  = pending[rd_addr];

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   ID/issue hazard unit: per-register scoreboard for long-latency writebacks,
//   youngest-first forwarding select over FWD_STAGES stages, single-outstanding
//   busy tracking per long unit, and a saturating issue-stall counter.
//
//   Ports
//     clk, reset_n                    clock, asynchronous active-low reset
//     issue_valid                     instruction present in ID
//     issue_rs1/rs2/rd                source and destination registers
//     issue_write_reg                 instruction writes rd
//     issue_long, issue_unit          goes to long-latency unit issue_unit
//     flush                           squash the ID instruction this cycle
//     stage_write_reg/rd/fwd_ok       per bypass stage (0 = youngest, EX)
//     complete_valid, cancel          per-unit writeback / kill
//     issue_ready                     no hazard, ID may advance
//     fwd_rs1/rs2                     0 = register file, k = stage k-1
//     unit_busy                       unit has its op outstanding
//     stall_cycles                    saturating count of stalled issue cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS   = DEF_NUM_REGS,
    parameter  int NUM_UNITS  = DEF_NUM_UNITS,
    parameter  int FWD_STAGES = DEF_FWD_STAGES,
    parameter  int CNT_W      = DEF_CNT_W,
    localparam int RW         = $clog2(NUM_REGS),
    localparam int UW         = clog2_min1(NUM_UNITS),
    localparam int FW         = $clog2(FWD_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    input  logic [RW-1:0]            issue_rs1,
    input  logic [RW-1:0]            issue_rs2,
    input  logic [RW-1:0]            issue_rd,
    input  logic                     issue_write_reg,
    input  logic                     issue_long,
    input  logic [UW-1:0]            issue_unit,
    input  logic                     flush,
    input  logic [FWD_STAGES-1:0]    stage_write_reg,
    input  logic [FWD_STAGES*RW-1:0] stage_rd,
    input  logic [FWD_STAGES-1:0]    stage_fwd_ok,
    input  logic [NUM_UNITS-1:0]     complete_valid,
    input  logic [NUM_UNITS-1:0]     cancel,
    output logic                     issue_ready,
    output logic [FW-1:0]            fwd_rs1,
    output logic [FW-1:0]            fwd_rs2,
    output logic [NUM_UNITS-1:0]     unit_busy,
    output logic [CNT_W-1:0]         stall_cycles
);

    logic [NUM_UNITS-1:0] busy;
    logic [NUM_UNITS-1:0] unit_clear;
    logic                 rs1_pending;
    logic                 rs2_pending;
    logic                 rd_pending;
    logic                 rs1_fwd_ok;
    logic                 rs2_fwd_ok;
    logic                 fire;
    logic                 stall_inc;
    hazard_t              haz;

    // Completion and cancel both just end the op; together they are one clear.
    assign unit_clear = complete_valid | cancel;

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_UNITS (NUM_UNITS)
    ) u_reg_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .set_en      (fire && issue_write_reg),
        .set_rd      (issue_rd),
        .set_unit    (issue_unit),
        .clr_mask    (unit_clear),
        .rs1_addr    (issue_rs1),
        .rs2_addr    (issue_rs2),
        .rd_addr     (issue_rd),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .rd_pending  (rd_pending)
    );

    // Forwarding select: walk oldest to youngest so the youngest match is
    // the last assignment and wins. Register 0 never forwards.
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fwd_rs1    = '0;
        fwd_rs2    = '0;
        rs1_fwd_ok = 1'b1;
        rs2_fwd_ok = 1'b1;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stage_write_reg[k] && (issue_rs1 != '0) &&
                (stage_rd[k*RW +: RW] == issue_rs1)) begin
                fwd_rs1    = FW'(k + 1);
                rs1_fwd_ok = stage_fwd_ok[k];
            end
            if (stage_write_reg[k] && (issue_rs2 != '0) &&
                (stage_rd[k*RW +: RW] == issue_rs2)) begin
                fwd_rs2    = FW'(k + 1);
                rs2_fwd_ok = stage_fwd_ok[k];
            end
        end
    end

    // Hazards use registered scoreboard/busy state only, so a completion or
    // cancel never unblocks an issue in the same cycle.
    always_comb begin
        haz.raw           = ((issue_rs1 != '0) && rs1_pending) ||
                            ((issue_rs2 != '0) && rs2_pending);
        haz.waw           = issue_write_reg && (issue_rd != '0) && rd_pending;
        haz.unit_conflict = issue_long && busy[issue_unit];
        haz.fwd_stall     = !rs1_fwd_ok || !rs2_fwd_ok;
    end

    assign issue_ready = ~|haz;
    assign fire        = issue_valid && issue_ready && !flush && issue_long;
    assign stall_inc   = issue_valid && !issue_ready && !flush;
    assign unit_busy   = busy;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the set below deliberately overrides the clear above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy & ~unit_clear;
            if (fire) begin
                busy[issue_unit] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the core's combinational hazard unit. Sits at the ID/issue boundary. It tracks long-latency writebacks (loads, divider, future units) in a per-register scoreboard instead of stalling the whole pipe on a unit wait. It also generalises forwarding to FWD_STAGES stages with per-stage result-ready flags, and counts issue-stall cycles for performance monitoring.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; index 0 is hard-wired zero.
- NUM_UNITS, 2: long-latency units, each single-outstanding (0 = load, 1 = divider).
- FWD_STAGES, 3: forwardable stages; index 0 is the youngest (EX).
- CNT_W, 32: width of the stall counter.

Ports (RW = $clog2(NUM_REGS), UW = $clog2(NUM_UNITS), FW = $clog2(FWD_STAGES+1)). Clock is `clk`; reset is `reset_n`, asynchronous, active-low.
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction present in ID
- issue_rs1, issue_rs2  in  RW  source registers
- issue_rd  in  RW  destination register
- issue_write_reg  in  1  instruction writes rd
- issue_long  in  1  instruction goes to a long-latency unit
- issue_unit  in  UW  target unit when issue_long
- flush  in  1  squash the ID instruction; no issue this cycle
- stage_write_reg  in  FWD_STAGES  per-stage write enable
- stage_rd  in  FWD_STAGES*RW  per-stage destination
- stage_fwd_ok  in  FWD_STAGES  per-stage result is valid for forwarding
- complete_valid  in  NUM_UNITS  unit u writes back this cycle
- cancel  in  NUM_UNITS  unit u's outstanding op is killed by a branch
- issue_ready  out  1  no hazard; the ID instruction may advance
- fwd_rs1, fwd_rs2  out  FW  0 = register file, k = stage k-1
- unit_busy  out  NUM_UNITS  unit holds an outstanding op
- stall_cycles  out  CNT_W  saturating stall count

## Operation
- State:
  - pending[NUM_REGS]: one bit per register.
  - owner[NUM_REGS]: UW bits per register.
  - busy[NUM_UNITS]: one bit per unit.
  - stall_cycles counter.
  - pending[0] is never set.
- issue_ready = !(raw || waw || struct || fwd_stall). Each term:
  - raw: rs1 or rs2 is nonzero and pending.
  - waw: issue_write_reg, rd nonzero, and pending[rd].
  - struct: issue_long and busy[issue_unit].
  - fwd_stall: for rs1 or rs2 (nonzero), the youngest matching stage (write_reg && rd==rs) has stage_fwd_ok=0.
- fwd_rsX: index+1 of the youngest stage k with stage_write_reg[k] and stage_rd[k]==rsX. It is 0 if there is no match or rsX=0. It is computed regardless of issue_ready.
- An issue fires on issue_valid && issue_ready && !flush && issue_long. On fire:
  - busy[issue_unit] is set.
  - If issue_write_reg and rd≠0, pending[rd] is set and owner[rd] is set to issue_unit.
- When complete_valid[u] or cancel[u] is asserted:
  - busy[u] is cleared.
  - Every r with pending[r] && owner[r]==u is cleared.
- Each cycle with issue_valid && !issue_ready && !flush increments stall_cycles. The counter saturates at all-ones.

## Timing
- Reset (async assert): pending, owner, busy and stall_cycles all go to 0. In that state issue_ready is 1 unless fwd_stall; fwd outputs are 0.
- issue_ready and fwd_rsX are combinational from inputs and registered state, with zero latency.
- Scoreboard updates on the clk rising edge and is visible the next cycle. A completion does not unblock a dependent issue in the same cycle. The dependent instruction issues one cycle later and takes its operand via the WB forward stage.
- Issue and complete/cancel of the same unit in the same cycle: struct is evaluated on the registered busy, so the issue stalls one cycle.
- Completion to a register and a fire on a different unit to the same rd in the same cycle cannot occur (waw blocks it).
- cancel and complete_valid on the same unit in the same cycle are equivalent to one clear.
- flush suppresses fire and the stall count but never clears scoreboard state. Only cancel does that.
- Reset deasserting mid-operation: all outstanding ops are forgotten. The units are reset by the same reset_n.

## Structure
- TYPES package gains `fwd_sel_t` (FW-bit) and a `long_unit_e` enum (LU_LOAD, LU_DIV) sized by NUM_UNITS.
- One natural sub-module, `reg_scoreboard`. It holds pending/owner and provides:
  - set (rd, unit)
  - clear-by-unit (NUM_UNITS mask)
  - three read ports (rs1, rs2, rd)
- The top level holds busy, the forwarding priority mux, the hazard logic and the counter.

## Test plan
- Reset with all inputs 0 -> issue_ready=1, fwd_rs1=fwd_rs2=0, stall_cycles=0, unit_busy=0.
- Div fire with rd=5; next cycle issue rs1=5 -> issue_ready=0 and stall_cycles counts 3 over 3 cycles. complete_valid[1] -> issue_ready=1 the cycle after.
- Stage0 rd=7 with fwd_ok=0 and stage1 rd=7 with fwd_ok=1; issue rs2=7 -> issue_ready=0 (youngest wins). Set stage0 fwd_ok=1 -> issue_ready=1, fwd_rs2=1.
- Load fire on rd=3, then load issue while busy[0] -> stall. cancel[0] -> pending[3] cleared; next-cycle issue with rs1=3 -> issue_ready=1, fwd_rs1=0.
- Long issue with rd=0 -> busy set, pending[0] stays 0. Issue rs1=0 -> no hazard, fwd_rs1=0.
- Preload stall_cycles near saturation by forcing it (CNT_W=4), then stall 20 cycles -> holds 15. Assert reset_n=0 mid-stall -> immediate 0.
